// File: rtl/range_tracker_pkg.sv
// range_tracker_pkg: shared types and constants for the range_tracker block.
//   state_e    - session FSM state
//   MODE_*     - readout select encodings driven on the mode port
//   sel_width  - width of a channel select for a given channel count
package range_tracker_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone,
    StError
  } state_e;

  localparam logic [1:0] MODE_RANGE = 2'd0;
  localparam logic [1:0] MODE_MIN   = 2'd1;
  localparam logic [1:0] MODE_MAX   = 2'd2;
  localparam logic [1:0] MODE_COUNT = 2'd3;

  function automatic int unsigned sel_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/range_tracker_if.sv
// range_tracker_if: sample, control and readout signals of range_tracker.
//   data_in/ch_sel/valid - tagged sample stream
//   go/finish            - session delimiters
//   mode/rd_sel          - readout select
//   result/result_valid/busy/error - registered readout and status
// master drives samples/control, slave is the tracker.
interface range_tracker_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CH = 4
);
  import range_tracker_pkg::*;

  localparam int unsigned CH_W = sel_width(NUM_CH);

  logic [WIDTH-1:0] data_in;
  logic [CH_W-1:0]  ch_sel;
  logic             valid;
  logic             go;
  logic             finish;
  logic [1:0]       mode;
  logic [CH_W-1:0]  rd_sel;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             busy;
  logic             error;

  modport master (
    output data_in, ch_sel, valid, go, finish, mode, rd_sel,
    input  result, result_valid, busy, error
  );

  modport slave (
    input  data_in, ch_sel, valid, go, finish, mode, rd_sel,
    output result, result_valid, busy, error
  );

endinterface

// File: rtl/range_tracker_ch.sv
// range_tracker_ch: running min/max/count for one channel.
//   clk, rst_n - clock, async active-low reset
//   clear      - restart the channel (min=all-ones, max=0, count=0)
//   upd        - fold data into the stats; applied after clear in the same cycle
//   data       - sample value
//   min/max/count/empty - current stats; count saturates at all-ones
module range_tracker_ch #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             upd,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] min,
  output logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    min_d   = min_q;
    max_d   = max_q;
    count_d = count_q;
    if (clear) begin
      min_d   = '1;
      max_d   = '0;
      count_d = '0;
    end
    if (upd) begin
      if (data < min_d) min_d = data;
      if (data > max_d) max_d = data;
      if (count_d != '1) count_d = count_d + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q   <= '1;
      max_q   <= '0;
      count_q <= '0;
    end else begin
      min_q   <= min_d;
      max_q   <= max_d;
      count_q <= count_d;
    end
  end

  assign min   = min_q;
  assign max   = max_q;
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/range_tracker.sv
// range_tracker: per-channel min/max/range/count over a go/finish session.
//   clk, rst_n - clock, async active-low reset
//   bus        - range_tracker_if.slave (samples, control, readout, status)
// Optional: define RANGE_TRACKER_LIVE_READOUT_EN to let result follow live
// channel stats in RUN and ERROR; otherwise result reads 0 outside DONE.
module range_tracker
  import range_tracker_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CH = 4
) (
  input logic           clk,
  input logic           rst_n,
  range_tracker_if.slave bus
);

  localparam int unsigned CH_W = sel_width(NUM_CH);

  state_e state_q, state_d;
  logic   clear, upd_en, ch_hit, rd_en;

  logic [NUM_CH-1:0] ch_hot, rd_hot, ch_empty;
  logic [WIDTH-1:0]  ch_min [NUM_CH];
  logic [WIDTH-1:0]  ch_max [NUM_CH];
  logic [WIDTH-1:0]  ch_cnt [NUM_CH];
  logic [WIDTH-1:0]  sel_val, result_q;

  // One-hot decode of both selects; an out-of-range select decodes to all zeros.
  always_comb begin
    ch_hot = '0;
    rd_hot = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_hot[i] = (bus.ch_sel == CH_W'(i));
      rd_hot[i] = (bus.rd_sel == CH_W'(i));
    end
  end

  assign ch_hit = |ch_hot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // A fresh session clears every channel and still accepts the go-cycle sample.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    upd_en  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.finish) begin
          state_d = StError;
        end else if (bus.go) begin
          state_d = StRun;
          clear   = 1'b1;
          upd_en  = bus.valid;
        end
      end
      StRun: begin
        if (bus.go || (bus.valid && !ch_hit)) begin
          state_d = StError;
        end else begin
          upd_en = bus.valid;
          if (bus.finish) state_d = StDone;
        end
      end
      StDone, StError: begin
        if (bus.go && bus.finish) begin
          state_d = StError;
        end else if (bus.go) begin
          state_d = StRun;
          clear   = 1'b1;
          upd_en  = bus.valid;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    range_tracker_ch #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .upd   (upd_en & ch_hot[g]),
      .data  (bus.data_in),
      .min   (ch_min[g]),
      .max   (ch_max[g]),
      .count (ch_cnt[g]),
      .empty (ch_empty[g])
    );
  end

  // Empty channels and unselected/out-of-range reads contribute 0.
  always_comb begin
    sel_val = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rd_hot[i] && !ch_empty[i]) begin
        case (bus.mode)
          MODE_RANGE: sel_val = ch_max[i] - ch_min[i];
          MODE_MIN:   sel_val = ch_min[i];
          MODE_MAX:   sel_val = ch_max[i];
          MODE_COUNT: sel_val = ch_cnt[i];
        endcase
      end
    end
  end

`ifdef RANGE_TRACKER_LIVE_READOUT_EN
  // IDLE is only reachable through reset, where every channel is empty.
  assign rd_en = (state_q != StIdle);
`else
  assign rd_en = (state_q == StDone);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) result_q <= '0;
    else        result_q <= rd_en ? sel_val : '0;
  end

  always_comb begin
    bus.result       = result_q;
    bus.busy         = (state_q == StRun);
    bus.result_valid = (state_q == StDone);
    bus.error        = (state_q == StError);
  end

endmodule

// File: doc/range_tracker.md
Name: range_tracker

Overview:
Multi-channel, parametrised successor to the single-stream range finder. Tracks running min, max, range and sample count for NUM_CH independent channels over a go/finish-delimited session. Sits behind the tt_um top wrapper: data on ui_in, control on uio_in, result on uo_out. Adds per-channel tagging, mode-selectable readout and a registered result/valid pair.

Parameters:
- WIDTH, 8, sample and result width in bits.
- NUM_CH, 4, number of independent channels (1..16).
- CH_W, localparam, `(NUM_CH>1) ? $clog2(NUM_CH) : 1`, width of channel selects.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  WIDTH  sample value, unsigned.
- ch_sel  in  CH_W  channel tag for data_in.
- valid  in  1  data_in/ch_sel qualify this cycle.
- go  in  1  start session (clears all channels).
- finish  in  1  end session.
- mode  in  2  readout select: 0 range, 1 min, 2 max, 3 count.
- rd_sel  in  CH_W  channel to read out.
- result  out  WIDTH  registered readout.
- result_valid  out  1  result holds final session data.
- busy  out  1  session in progress.
- error  out  1  protocol error flag.

Behaviour:
- Reset (async, rst_n=0): state IDLE; result=0, result_valid=0, busy=0, error=0; every channel min=all-ones, max=0, count=0.
- FSM states: IDLE, RUN, DONE, ERROR. All flags are registered and decoded from state: busy=RUN, result_valid=DONE, error=ERROR.
- IDLE:
  - go & !finish -> RUN; all channels cleared the same edge.
  - finish (with or without go) -> ERROR.
- RUN:
  - valid -> update channel ch_sel: min=min(min,data), max=max(max,data), count+1 saturating at 2^WIDTH-1.
  - finish & !go -> DONE. A valid sample in the finish cycle is included.
  - go (any) -> ERROR; the sample in that cycle is discarded.
- DONE:
  - go & !finish -> RUN with clear.
  - finish alone is ignored; go & finish -> ERROR.
- ERROR:
  - Channel contents frozen.
  - go & !finish -> RUN with clear; error drops on that edge. Otherwise stay.
- Sample on go cycle: when go & valid in IDLE/DONE/ERROR, the sample is counted into the freshly cleared channel (clear has priority, then update).
- Out-of-range tag: valid with ch_sel >= NUM_CH in RUN -> ERROR; no channel is updated.
- valid outside RUN (other than the go cycle) is ignored.
- Readout: result is registered with 1-cycle latency from rd_sel/mode changes.
  - range = max-min, WIDTH bits, never negative.
  - Channel with count=0 reads 0 in every mode.
  - rd_sel >= NUM_CH reads 0.
- Without the live-readout feature, result is forced to 0 whenever state != DONE.

Optional Feature:
- Macro: RANGE_TRACKER_LIVE_READOUT_EN.
- Defined: result also tracks live channel stats in RUN and ERROR. Same 1-cycle latency. Updates from a sample appear 2 cycles after the valid edge. result_valid is still DONE-only.
- Undefined: result=0 outside DONE; the extra mux path is removed.

Decomposition:
- range_tracker_pkg:
  - state enum (IDLE, RUN, DONE, ERROR).
  - mode constants MODE_RANGE=0, MODE_MIN=1, MODE_MAX=2, MODE_COUNT=3.
- Sub-module range_tracker_ch, generated NUM_CH times:
  - Holds min/max/count for one channel.
  - Inputs: clear, upd, data.
  - Outputs: min, max, count, empty.
- Top level holds the FSM, ch_sel decode and the readout mux/register.

Test Plan:
1. Reset, then go, then samples 0x10,0x80,0x05 on ch0, then finish. Read ch0 -> range=0x7B, min=0x05, max=0x80, count=3; result_valid=1.
2. Interleave ch1=0x20, ch2=0xF0, ch1=0x30, ch2=0x01 and finish. Read ch1 -> range=0x10; ch2 -> range=0xEF; ch3 -> all modes 0.
3. go & valid(0x44, ch0) in the same cycle, then finish immediately. Read ch0 -> count=1, min=max=0x44, range=0.
4. Protocol errors, each from a known state:
   - finish in IDLE -> error=1 next cycle.
   - go in RUN -> error=1 next cycle.
   - Then go alone -> error=0, busy=1, all channels cleared.
5. Send 300 samples of 0x01 on ch0 with WIDTH=8 -> count saturates at 0xFF.
6. Assert rst_n=0 mid-RUN -> all outputs 0 immediately, without waiting for a clock edge. With RANGE_TRACKER_LIVE_READOUT_EN defined, result in RUN follows max two cycles after each update.
